// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner issuing single-outstanding imem fetches into a small FIFO for decode, with redirect/flush.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] data_q [FIFO_DEPTH];
    logic [31:0] data_d [FIFO_DEPTH];
    logic [31:0] tag_q [FIFO_DEPTH];
    logic [31:0] tag_d [FIFO_DEPTH];
    logic accept, push, pop, credit;
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q  <= RESET_PC;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        data_q <= data_d;
        tag_q  <= tag_d;
    end
    always_comb begin
        accept = state_q == REQ && imem_ready_i;
        push   = state_q == WAIT && imem_rvalid_i && !redirect_i;
        pop    = instr_valid_o && instr_ready_i && !redirect_i;
        cnt_d  = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        credit = cnt_d < CW'(FIFO_DEPTH);
        wr_d   = redirect_i ? '0 : wr_q + PW'(push);
        rd_d   = redirect_i ? '0 : rd_q + PW'(pop);
        pc_d   = redirect_i ? (redirect_pc_i & ~32'h3) : accept ? pc_q + 32'd4 : pc_q;
        data_d = data_q;
        tag_d  = tag_q;
        // In WAIT the PC has already advanced past the outstanding fetch
        if (push) begin
            data_d[wr_q] = imem_rdata_i;
            tag_d[wr_q]  = pc_q - 32'd4;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start_i && credit) ? REQ : IDLE;
            REQ:     state_d = imem_ready_i ? (redirect_i ? KILL : WAIT) : REQ;
            WAIT:    state_d = imem_rvalid_i ? ((start_i && credit) ? REQ : IDLE) : (redirect_i ? KILL : WAIT);
            KILL:    state_d = imem_rvalid_i ? IDLE : KILL;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        imem_req_o    = state_q == REQ;
        imem_addr_o   = pc_q;
        instr_valid_o = cnt_q != '0;
        instr_o       = instr_valid_o ? data_q[rd_q] : '0;
        instr_pc_o    = instr_valid_o ? tag_q[rd_q] : '0;
    end
    assert property (@(posedge clk_i) disable iff (rst_i) push |-> cnt_q < CW'(FIFO_DEPTH));
endmodule
